pair_drain_ctrl: RTL
====================

# pair_drain_ctrl

Read-side controller for the two-lane synchronous tuple FIFO (two 64-bit lanes, one shared `read_en`, one combined `empty`). It pops one lane pair at a time and holds it in a capture register. It then serializes the pair onto a single 64-bit valid/ready stream, lane 0 first, toward the downstream hash/probe stage. When the consumer is ready, it prefetches the next pair so the FIFO's one-cycle read latency is partly hidden.

## Interface
- `DATA_W`, 64, width of each FIFO lane and of the output word
- `CNT_W`, 32, width of the statistics counters
- `clk`  in  1  single clock; all logic is rising-edge
- `rst`  in  1  asynchronous, active-low reset
- `drain_en_in`  in  1  permits new FIFO pops; an in-flight pair always completes
- `fifo_empty_in`  in  1  combined empty from the FIFO, high if either lane is empty
- `fifo_read_en_out`  out  1  pops both lanes; FIFO data is valid on the cycle after assertion
- `fifo_data_1_in`  in  DATA_W  lane 1 FIFO output
- `fifo_data_0_in`  in  DATA_W  lane 0 FIFO output
- `out_valid_out`  out  1  output word valid
- `out_ready_in`  in  1  consumer accepts the word when valid and ready are both high
- `out_data_out`  out  DATA_W  serialized word
- `out_lane_out`  out  1  source lane of the current word: 0, then 1
- `idle_out`  out  1  high in IDLE with no pair held
- `pair_count_out`  out  CNT_W  pairs fully emitted (stats)
- `stall_count_out`  out  CNT_W  cycles with valid high and ready low (stats)

## Operation
- The FSM has four states: IDLE, LAT, SEND0, SEND1.
- **IDLE:** `fifo_read_en_out = drain_en_in & ~fifo_empty_in`. If asserted, go to LAT.
- **LAT:** capture `fifo_data_0_in` and `fifo_data_1_in` into the pair register, then go to SEND0. `fifo_read_en_out` is low.
- **SEND0:** `out_valid_out` high, `out_data_out` = lane 0, `out_lane_out` = 0. On handshake, go to SEND1. Otherwise hold.
- **SEND1:** `out_valid_out` high, `out_data_out` = lane 1, `out_lane_out` = 1. On handshake:
  - increment `pair_count_out`;
  - if `drain_en_in & ~fifo_empty_in`, assert `fifo_read_en_out` in the same cycle and go to LAT (prefetch);
  - otherwise go to IDLE.
- `fifo_read_en_out` is combinational (Mealy). It is asserted only in IDLE, or in SEND1 on a handshake. At most one pair is outstanding, so FIFO underflow is impossible.
- Word order is lane 0 then lane 1. Pairs leave in FIFO order.
- `out_data_out` and `out_lane_out` are stable while valid is high and ready is low. Valid never drops without a handshake.
- Deasserting `drain_en_in` mid-pair still completes SEND0 and SEND1 for that pair. Only new pops are blocked.
- Counters wrap modulo 2^CNT_W and do not saturate.

## Timing
- Reset values: state IDLE, pair register 0, `out_valid_out` 0, `out_data_out` 0, `out_lane_out` 0, `fifo_read_en_out` 0, `idle_out` 1, both counters 0.
- Reset mid-pair discards the held pair. The FIFO is reset on the same reset, so no tuple is left orphaned.
- Pop to first output word: 2 cycles (pop in cycle N, LAT in N+1, SEND0 valid in N+2).
- Steady-state throughput with ready held high is 2 words per 3 cycles (SEND0, SEND1, LAT).
- `fifo_empty_in` is sampled only in the cycle a pop is decided. A simultaneous write into an empty FIFO is picked up on the next decision point.

## Configuration
- `PAIR_DRAIN_STATS_EN` defined:
  - `pair_count_out` and `stall_count_out` are live registers as described above;
  - `stall_count_out` increments in every SEND0/SEND1 cycle with `out_ready_in` low.
- `PAIR_DRAIN_STATS_EN` undefined:
  - no counter flops are built;
  - both ports are tied to 0;
  - all other behaviour is identical.

## Structure
- Package `pair_drain_pkg` holds:
  - the state enum (IDLE, LAT, SEND0, SEND1);
  - the lane constants `LANE_0 = 1'b0`, `LANE_1 = 1'b1`;
  - the default widths `DATA_W` and `CNT_W`.
- Sub-module `pair_drain_stats` contains both counters and is instantiated only under `PAIR_DRAIN_STATS_EN`. The FSM, pair register and read strobe stay in the top module.

## Test plan
- **Single pair.** After reset, push one pair (lane0 = 0xA, lane1 = 0xB), ready high. Expect:
  - read_en pulses once;
  - valid in cycles +2 and +3 with data 0xA/lane 0, then 0xB/lane 1;
  - then IDLE, `idle_out` = 1, pair_count = 1.
- **Streaming.** Push 4 pairs (0x10/0x11 … 0x40/0x41), ready high. Expect:
  - 8 words in FIFO order;
  - read_en pulses on each SEND1 handshake;
  - 3-cycle pair cadence;
  - pair_count = 4.
- **Backpressure.** Hold ready low for 5 cycles during SEND0. Expect:
  - data/lane stable;
  - no read_en;
  - stall_count = 5;
  - the order resumes unchanged once ready rises.
- **Drain disable.** Drop `drain_en_in` during SEND0 with 2 pairs queued. Expect:
  - the current pair finishes;
  - no further read_en;
  - after `drain_en_in` is re-raised, the remaining pair is emitted.
- **Reset mid-pair.** Assert `rst` low in SEND1. Expect all outputs to reach their reset values immediately (asynchronously) and no spurious valid after release.
- **Stats compiled out.** Run the streaming scenario built without `PAIR_DRAIN_STATS_EN`. Expect both counter ports to read 0 and an identical output stream.

Source files
------------

// File: rtl/pair_drain_pkg.sv
// Shared types and default widths for the two-lane pair drain controller.
package pair_drain_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;

    localparam logic LANE_0 = 1'b0;
    localparam logic LANE_1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAT   = 2'd1,
        SEND0 = 2'd2,
        SEND1 = 2'd3
    } state_t;

endpackage

// File: rtl/pair_drain_stats.sv
// Pair and stall statistics counters; both wrap modulo 2^CNT_W.
module pair_drain_stats #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pair_done,
    input  logic             stall,
    output logic [CNT_W-1:0] pair_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pair_done) pair_count  <= pair_count + ONE;
            if (stall)     stall_count <= stall_count + ONE;
        end
    end

endmodule

// File: rtl/pair_drain_ctrl.sv
// Pops lane pairs from the two-lane FIFO and serializes them lane 0 then lane 1.
// Statistics counters are built only when PAIR_DRAIN_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | no pair held; pop when drain enabled and FIFO not empty
//   LAT   | FIFO read latency; capture both lanes
//   SEND0 | present lane 0 word
//   SEND1 | present lane 1 word; prefetch next pair on handshake
module pair_drain_ctrl #(
    parameter int DATA_W = pair_drain_pkg::DATA_W,
    parameter int CNT_W  = pair_drain_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drain_en_in,
    input  logic              fifo_empty_in,
    output logic              fifo_read_en_out,
    input  logic [DATA_W-1:0] fifo_data_1_in,
    input  logic [DATA_W-1:0] fifo_data_0_in,
    output logic              out_valid_out,
    input  logic              out_ready_in,
    output logic [DATA_W-1:0] out_data_out,
    output logic              out_lane_out,
    output logic              idle_out,
    output logic [CNT_W-1:0]  pair_count_out,
    output logic [CNT_W-1:0]  stall_count_out
);

    import pair_drain_pkg::*;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] lane0_q;
    logic [DATA_W-1:0] lane1_q;
    logic              pop_ok;

    // Empty is only consulted at a pop decision, never while a pair is in flight.
    assign pop_ok = drain_en_in & ~fifo_empty_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane0_q <= '0;
            lane1_q <= '0;
        end else if (state == LAT) begin
            lane0_q <= fifo_data_0_in;
            lane1_q <= fifo_data_1_in;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop_ok) next_state = LAT;
            LAT:     next_state = SEND0;
            SEND0:   if (out_ready_in) next_state = SEND1;
            SEND1:   if (out_ready_in) next_state = pop_ok ? LAT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        fifo_read_en_out = 1'b0;
        out_valid_out    = 1'b0;
        out_data_out     = '0;
        out_lane_out     = LANE_0;
        idle_out         = 1'b0;
        case (state)
            IDLE: begin
                fifo_read_en_out = pop_ok;
                idle_out         = 1'b1;
            end
            SEND0: begin
                out_valid_out = 1'b1;
                out_data_out  = lane0_q;
                out_lane_out  = LANE_0;
            end
            SEND1: begin
                out_valid_out    = 1'b1;
                out_data_out     = lane1_q;
                out_lane_out     = LANE_1;
                fifo_read_en_out = out_ready_in & pop_ok;
            end
            default: ;
        endcase
    end

`ifdef PAIR_DRAIN_STATS_EN
    pair_drain_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk         (clk),
        .rst         (rst),
        .pair_done   (state == SEND1 && out_ready_in),
        .stall       (out_valid_out && !out_ready_in),
        .pair_count  (pair_count_out),
        .stall_count (stall_count_out)
    );
`else
    assign pair_count_out  = '0;
    assign stall_count_out = '0;
`endif

endmodule
